// File: rtl/rr_arb_mux_pkg.sv
// Shared encodings for the round-robin / fixed-select arbitrating mux.
// Mode and output-register state enums live here so every file agrees on them.
package rr_arb_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// Cyclic priority search: first requester after ptr, wrapping, ending at ptr itself.
// Purely combinational; ptr is assumed to be a legal channel index.
module rr_prio_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [SELW-1:0]     grant,
    output logic                grant_valid
);

    // Channel index offset positions after base, modulo CHANNELS.
    function automatic logic [SELW-1:0] step(input logic [SELW-1:0] base, input int offset);
        int sum;
        sum = (int'(base) + offset) % CHANNELS;
        return SELW'(sum);
    endfunction

    // rot[i] is the request of the channel i+1 places after ptr.
    logic [CHANNELS-1:0] rot;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rot
            assign rot[gi] = req[step(ptr, gi + 1)];
        end
    endgenerate

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant       = step(ptr, i + 1);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux feeding a one-entry output register.
// Fixed-select or round-robin grant; full throughput when downstream is ready.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      mode_in,
    input  logic [SELW-1:0]           set_in,
    input  logic [CHANNELS*WIDTH-1:0] a_in,
    input  logic [CHANNELS-1:0]       a_valid_in,
    output logic [CHANNELS-1:0]       a_ready_out,
    output logic [WIDTH-1:0]          y_out,
    output logic [SELW-1:0]           y_chan_out,
    output logic                      y_valid_out,
    input  logic                      y_ready_in
);

    localparam int SEL_SPAN = 1 << SELW;

    mode_e               mode;
    state_e              state_reg, state_next;
    logic [SELW-1:0]     ptr_reg, ptr_next;
    logic [WIDTH-1:0]    data_reg, data_next;
    logic [SELW-1:0]     chan_reg, chan_next;

    logic [WIDTH-1:0]    chan_data [CHANNELS];
    logic [SEL_SPAN-1:0] valid_pad;
    logic [SELW-1:0]     rr_grant;
    logic                rr_grant_valid;
    logic                fix_grant_valid;
    logic [SELW-1:0]     grant_idx;
    logic                grant_valid;
    logic                can_load;
    logic                load;
    logic [WIDTH-1:0]    data_sel;

    assign mode = mode_e'(mode_in);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign chan_data[gi] = a_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_prio_pick #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_pick (
        .req         (a_valid_in),
        .ptr         (ptr_reg),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    // Zero-padded valids make a select beyond CHANNELS-1 read as "not valid".
    assign valid_pad       = SEL_SPAN'(a_valid_in);
    assign fix_grant_valid = valid_pad[set_in];

    assign grant_idx   = (mode == MODE_RR) ? rr_grant : set_in;
    assign grant_valid = (mode == MODE_RR) ? rr_grant_valid : fix_grant_valid;
    assign can_load    = (state_reg == ST_EMPTY) || y_ready_in;
    assign load        = can_load && grant_valid;

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SELW'(k)) begin
                data_sel = chan_data[k];
            end
        end
    end

    // Ready is forced low while reset is held, not just after the next edge.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign a_ready_out[gi] = rst_n_in && load && (grant_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        data_next  = data_reg;
        chan_next  = chan_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (load) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (load) begin
                    state_next = ST_FULL;
                end else if (y_ready_in) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (load) begin
            data_next = data_sel;
            chan_next = grant_idx;
            if (mode == MODE_RR) begin
                ptr_next = grant_idx;
            end
        end
    end

    // ptr resets to the last channel so channel 0 wins the first round-robin search.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= ST_EMPTY;
            ptr_reg   <= SELW'(CHANNELS - 1);
            data_reg  <= '0;
            chan_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            data_reg  <= data_next;
            chan_reg  <= chan_next;
        end
    end

    assign y_out       = data_reg;
    assign y_chan_out  = chan_reg;
    assign y_valid_out = (state_reg == ST_FULL);

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel instance plus a 3-channel one
// for the out-of-range select case.
module tb_rr_arb_mux;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  set_sel;
    logic [31:0] a_data;
    logic [3:0]  a_valid;
    logic [3:0]  a_ready;
    logic [7:0]  y_data;
    logic [1:0]  y_chan;
    logic        y_valid;
    logic        y_ready;

    logic        mode3;
    logic [1:0]  set3;
    logic [23:0] a3;
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic [7:0]  y3;
    logic [1:0]  chan3;
    logic        yvalid3;
    logic        yready3;

    int tests;
    int fails;

    rr_arb_mux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .mode_in     (mode),
        .set_in      (set_sel),
        .a_in        (a_data),
        .a_valid_in  (a_valid),
        .a_ready_out (a_ready),
        .y_out       (y_data),
        .y_chan_out  (y_chan),
        .y_valid_out (y_valid),
        .y_ready_in  (y_ready)
    );

    rr_arb_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .mode_in     (mode3),
        .set_in      (set3),
        .a_in        (a3),
        .a_valid_in  (valid3),
        .a_ready_out (ready3),
        .y_out       (y3),
        .y_chan_out  (chan3),
        .y_valid_out (yvalid3),
        .y_ready_in  (yready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        mode    = 1'b1;
        set_sel = 2'd0;
        a_data  = 32'h13121110;
        a_valid = 4'b1111;
        y_ready = 1'b1;
        #12;
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        tests++; if (a_ready !== 4'b0000) begin fails++; $display("FAIL reset_a_ready: got %b expected 0000", a_ready); end
        tests++; if (y_data !== 8'h00 || y_chan !== 2'd0) begin fails++; $display("FAIL reset_y_regs: got data %h chan %0d expected 00/0", y_data, y_chan); end
        tick();
        rst_n = 1'b1;
        #1;
        tests++; if (a_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: got %b expected 0001", a_ready); end
        $display("[TB] reset: a_ready=%b after release", a_ready);
        a_valid = 4'b0000;
        tick();
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_idle: got %b expected 0", y_valid); end
    endtask

    task automatic test_fixed();
        mode    = 1'b0;
        set_sel = 2'd2;
        a_data  = 32'h13A51110;
        a_valid = 4'b1111;
        #1;
        tests++; if (a_ready !== 4'b0100) begin fails++; $display("FAIL fixed_ready: got %b expected 0100", a_ready); end
        tick();
        $display("[TB] fixed: y_out=%h chan=%0d valid=%b", y_data, y_chan, y_valid);
        tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL fixed_valid: got %b expected 1", y_valid); end
        tests++; if (y_data !== 8'hA5) begin fails++; $display("FAIL fixed_data: got %h expected a5", y_data); end
        tests++; if (y_chan !== 2'd2) begin fails++; $display("FAIL fixed_chan: got %0d expected 2", y_chan); end
        a_valid = 4'b0000;
        tick();
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL fixed_drain: got %b expected 0", y_valid); end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_chan;
        logic [7:0] exp_data;
        mode    = 1'b1;
        a_data  = 32'h13121110;
        a_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_chan = 2'(i % 4);
            exp_data = 8'h10 + 8'(i % 4);
            $display("[TB] rr beat %0d: chan=%0d data=%h valid=%b", i, y_chan, y_data, y_valid);
            tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, y_valid); end
            tests++; if (y_chan !== exp_chan || y_data !== exp_data) begin
                fails++; $display("FAIL rr_seq[%0d]: got chan %0d data %h expected chan %0d data %h", i, y_chan, y_data, exp_chan, exp_data);
            end
        end
        a_valid = 4'b0000;
        tick();
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL rr_drain: got %b expected 0", y_valid); end
    endtask

    task automatic test_backpressure();
        mode    = 1'b1;
        a_data  = 32'h13121110;
        a_valid = 4'b1111;
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        #1;
        tests++; if (y_valid !== 1'b1 || y_chan !== 2'd0 || y_data !== 8'h10) begin
            fails++; $display("FAIL bp_load: got valid %b chan %0d data %h expected 1/0/10", y_valid, y_chan, y_data);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("[TB] stall %0d: data=%h a_ready=%b", i, y_data, a_ready);
            tests++; if (y_valid !== 1'b1 || y_data !== 8'h10 || y_chan !== 2'd0 || a_ready !== 4'b0000) begin
                fails++; $display("FAIL bp_stall[%0d]: got valid %b data %h chan %0d ready %b expected 1/10/0/0000", i, y_valid, y_data, y_chan, a_ready);
            end
        end
        y_ready = 1'b1;
        #1;
        tests++; if (a_ready !== 4'b0010) begin fails++; $display("FAIL bp_release_ready: got %b expected 0010", a_ready); end
        tick();
        tests++; if (y_chan !== 2'd1 || y_data !== 8'h11) begin fails++; $display("FAIL bp_next_beat: got chan %0d data %h expected 1/11", y_chan, y_data); end
        a_valid = 4'b0000;
        tick();
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", y_valid); end
    endtask

    task automatic test_wrap_skip();
        mode    = 1'b1;
        a_valid = 4'b0100;
        #1;
        tests++; if (a_ready !== 4'b0100) begin fails++; $display("FAIL wrap_set_ptr: got %b expected 0100", a_ready); end
        tick();
        tests++; if (y_chan !== 2'd2) begin fails++; $display("FAIL wrap_chan2: got %0d expected 2", y_chan); end
        a_valid = 4'b1001;
        #1;
        tests++; if (a_ready !== 4'b1000) begin fails++; $display("FAIL wrap_ready3: got %b expected 1000", a_ready); end
        tick();
        $display("[TB] wrap: chan=%0d data=%h", y_chan, y_data);
        tests++; if (y_chan !== 2'd3 || y_data !== 8'h13) begin fails++; $display("FAIL wrap_chan3: got chan %0d data %h expected 3/13", y_chan, y_data); end
        tests++; if (a_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ready0: got %b expected 0001", a_ready); end
        tick();
        $display("[TB] wrap: chan=%0d data=%h", y_chan, y_data);
        tests++; if (y_chan !== 2'd0 || y_data !== 8'h10) begin fails++; $display("FAIL wrap_chan0: got chan %0d data %h expected 0/10", y_chan, y_data); end
        a_valid = 4'b0000;
        tick();
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL wrap_drain: got %b expected 0", y_valid); end
    endtask

    task automatic test_reset_mid_transfer();
        mode    = 1'b1;
        a_valid = 4'b1111;
        tick();
        tests++; if (y_valid !== 1'b1 || y_chan !== 2'd1) begin fails++; $display("FAIL midrst_load: got valid %b chan %0d expected 1/1", y_valid, y_chan); end
        y_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] mid-transfer reset: valid=%b data=%h a_ready=%b", y_valid, y_data, a_ready);
        tests++; if (y_valid !== 1'b0 || y_data !== 8'h00 || y_chan !== 2'd0 || a_ready !== 4'b0000) begin
            fails++; $display("FAIL midrst_clear: got valid %b data %h chan %0d ready %b expected 0/00/0/0000", y_valid, y_data, y_chan, a_ready);
        end
        tick();
        rst_n   = 1'b1;
        y_ready = 1'b1;
        #1;
        tests++; if (a_ready !== 4'b0001) begin fails++; $display("FAIL midrst_first_grant: got %b expected 0001", a_ready); end
        tick();
        tests++; if (y_chan !== 2'd0 || y_valid !== 1'b1) begin fails++; $display("FAIL midrst_beat: got chan %0d valid %b expected 0/1", y_chan, y_valid); end
        a_valid = 4'b0000;
        tick();
    endtask

    task automatic test_out_of_range();
        mode3   = 1'b0;
        set3    = 2'd3;
        a3      = 24'h222120;
        valid3  = 3'b111;
        yready3 = 1'b1;
        #1;
        tests++; if (ready3 !== 3'b000) begin fails++; $display("FAIL oor_ready: got %b expected 000", ready3); end
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("[TB] oor cycle %0d: y_valid=%b ready=%b", i, yvalid3, ready3);
            tests++; if (yvalid3 !== 1'b0) begin fails++; $display("FAIL oor_valid[%0d]: got %b expected 0", i, yvalid3); end
        end
        set3 = 2'd1;
        #1;
        tests++; if (ready3 !== 3'b010) begin fails++; $display("FAIL oor_legal_ready: got %b expected 010", ready3); end
        tick();
        tests++; if (yvalid3 !== 1'b1 || chan3 !== 2'd1 || y3 !== 8'h21) begin
            fails++; $display("FAIL oor_legal_beat: got valid %b chan %0d data %h expected 1/1/21", yvalid3, chan3, y3);
        end
        valid3 = 3'b000;
        tick();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        mode3   = 1'b0;
        set3    = 2'd0;
        a3      = 24'h0;
        valid3  = 3'b000;
        yready3 = 1'b1;
        test_reset();
        test_fixed();
        test_rr_fairness();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid_transfer();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, sets the data bits per channel (1..64).
REQ-002 Parameter CHANNELS, default 4, sets the number of input channels (2..16).
REQ-003 Parameter SELW, default $clog2(CHANNELS), sets the select/channel-index width.
REQ-004 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 mode_in  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-007 set_in  input  SELW  channel select, used only when mode_in = 0.
REQ-008 a_in  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 a_valid_in  input  CHANNELS  per-channel valid.
REQ-010 a_ready_out  output  CHANNELS  per-channel ready, one-hot or zero.
REQ-011 y_out  output  WIDTH  registered output data.
REQ-012 y_chan_out  output  SELW  index of the channel that supplied y_out.
REQ-013 y_valid_out  output  1  output holds a valid beat.
REQ-014 y_ready_in  input  1  downstream accepts a beat.

Function
REQ-015 Input channel k transfers when a_valid_in[k] and a_ready_out[k] are both 1 on a rising edge. Output transfers when y_valid_out and y_ready_in are both 1.
REQ-016 The block has a one-entry output register with states EMPTY (y_valid_out = 0) and FULL (y_valid_out = 1).
REQ-017 can_load = EMPTY, or FULL with y_ready_in = 1. a_ready_out[g] = 1 only for the granted channel g, and only when can_load = 1. All other bits are 0.
REQ-018 In mode 0, g = set_in, granted only if a_valid_in[set_in] = 1. If set_in >= CHANNELS, no channel is granted.
REQ-019 In mode 1, g is the first channel with valid = 1, searching cyclically from ptr+1 through ptr (wrapping at CHANNELS-1 to 0). If no channel is valid, there is no grant.
REQ-020 ptr is updated to g only on an input transfer in mode 1. It is unchanged by mode-0 transfers and by idle cycles.
REQ-021 The grant is combinational from the current inputs and state. Latency from input transfer to y_valid_out = 1 is exactly one cycle.
REQ-022 Transitions:
- EMPTY + input transfer -> FULL.
- FULL + output transfer without input transfer -> EMPTY.
- FULL + output and input transfer in the same cycle -> FULL, with the new beat loaded (back-to-back throughput of one beat per clock).
- FULL + y_ready_in = 0 -> hold.
REQ-023 While FULL and stalled, y_out and y_chan_out shall remain stable, and all a_ready_out bits shall be 0.
REQ-024 A change of mode_in or set_in shall take effect on the next grant computation only. A beat already in the register is unaffected.
REQ-025 There is no data width arithmetic: y_out is a bit-exact copy of the granted WIDTH-bit slice.
REQ-026 When no channel is valid, nothing is loaded, and the block never emits a spurious beat.

Reset
REQ-027 While rst_n_in = 0, immediately and independently of clk_in:
- state = EMPTY, y_valid_out = 0, y_out = 0, y_chan_out = 0;
- ptr = CHANNELS-1, so that channel 0 has first priority;
- a_ready_out = 0.
REQ-028 Reset asserted mid-transfer shall discard the held beat. After deassertion, the first grant follows REQ-018/REQ-019 from the reset state.

Structure
REQ-029 The mode encodings (MODE_FIXED = 0, MODE_RR = 1) and the EMPTY/FULL state encoding shall reside in a shared package, rr_arb_mux_pkg.
REQ-030 The round-robin priority search shall be one sub-module, rr_prio_pick, taking a CHANNELS-bit request vector and ptr, and returning a grant index and a grant-valid flag.

Verification
REQ-031 Reset sanity: hold rst_n_in = 0 with all a_valid_in = 1. Require y_valid_out = 0 and a_ready_out = 0. Deassert reset in mode 1: a_ready_out = 0001.
REQ-032 Fixed select: mode 0, set_in = 2, channel 2 data 0xA5 valid, y_ready_in = 1. Require y_out = 0xA5 and y_chan_out = 2 one cycle later, and no other channel granted.
REQ-033 Round-robin fairness: mode 1, all four channels valid continuously, y_ready_in = 1. Require the y_chan_out sequence 0,1,2,3,0,... with y_valid_out = 1 every cycle.
REQ-034 Backpressure: mode 1, y_ready_in = 0 for 5 cycles while FULL. Require y_out stable and a_ready_out = 0 throughout. Raise y_ready_in: the next beat loads the same cycle.
REQ-035 Wrap and skip: ptr = 2, valids = 1001. Require grant to channel 3, then channel 0.
REQ-036 Out-of-range select: CHANNELS = 3, mode 0, set_in = 3. Require no grant and y_valid_out remaining 0.
